// File: rtl/gcd_operand_feeder.sv
// Operand FIFO and issue/collect sequencer in front of gcdmodel.
// Pairs are issued one at a time; each result is returned tagged with its operands.
module gcd_operand_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_input_available,
    output logic [WIDTH-1:0] gcd_operand_a,
    output logic [WIDTH-1:0] gcd_operand_b,
    input  logic             gcd_idle,
    input  logic             gcd_result_rdy,
    input  logic [WIDTH-1:0] gcd_result_data,
    output logic             gcd_result_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CNT_W-1:0] fifo_count
);

    // state    | meaning
    // IDLE     | waiting for a queued pair and an idle GCD
    // ISSUE    | input_available high; head popped and tagged at exit
    // WAIT_RES | waiting for result_rdy and a free output slot
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RES = 2'd2;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_a_d [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] mem_b_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] tag_a_q, tag_a_d;
    logic [WIDTH-1:0] tag_b_q, tag_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;

    logic push;
    logic pop;
    logic slot_free;
    logic out_pop;

    assign in_ready            = (count_q != CNT_W'(DEPTH));
    assign push                = in_valid & in_ready;
    assign pop                 = (state_q == ST_ISSUE);
    assign slot_free           = !out_valid_q | out_ready;
    assign out_pop             = out_valid_q & out_ready;
    assign gcd_input_available = (state_q == ST_ISSUE);
    assign gcd_result_taken    = (state_q == ST_WAIT_RES) & gcd_result_rdy & slot_free;
    assign gcd_operand_a       = mem_a_q[rd_ptr_q];
    assign gcd_operand_b       = mem_b_q[rd_ptr_q];

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign fifo_count = count_q;

    always_comb begin
        mem_a_d      = mem_a_q;
        mem_b_d      = mem_b_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        tag_a_d      = tag_a_q;
        tag_b_d      = tag_b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;

        if (push) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            tag_a_d  = mem_a_q[rd_ptr_q];
            tag_b_d  = mem_b_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && gcd_idle) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (gcd_result_taken) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A capture at the same edge as a consumer pop keeps the slot full
        if (gcd_result_taken) begin
            out_valid_d  = 1'b1;
            out_result_d = gcd_result_data;
            out_a_d      = tag_a_q;
            out_b_d      = tag_b_q;
        end else if (out_pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            tag_a_q      <= '0;
            tag_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
        end else begin
            mem_a_q      <= mem_a_d;
            mem_b_q      <= mem_b_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            tag_a_q      <= tag_a_d;
            tag_b_q      <= tag_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
        end
    end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a small behavioural GCD engine
// standing in for gcdmodel; expected results are hand-computed constants.
module tb_gcd_operand_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        gcd_input_available;
    logic [15:0] gcd_operand_a;
    logic [15:0] gcd_operand_b;
    logic        gcd_idle;
    logic        gcd_result_rdy;
    logic [15:0] gcd_result_data;
    logic        gcd_result_taken;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [2:0]  fifo_count;

    gcd_operand_feeder #(.WIDTH(16), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_input_available(gcd_input_available),
        .gcd_operand_a(gcd_operand_a), .gcd_operand_b(gcd_operand_b),
        .gcd_idle(gcd_idle), .gcd_result_rdy(gcd_result_rdy),
        .gcd_result_data(gcd_result_data), .gcd_result_taken(gcd_result_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_a(out_a), .out_b(out_b),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // behavioural GCD engine state, updated only from tick()
    logic        g_busy = 1'b0;
    logic        g_rdy = 1'b0;
    logic [15:0] g_res = '0;
    int          g_lat = 0;
    int          lat_cfg = 2;
    logic        idle_block = 1'b0;

    assign gcd_idle        = !g_busy && !g_rdy && !idle_block;
    assign gcd_result_rdy  = g_rdy;
    assign gcd_result_data = g_res;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] a;
        logic [15:0] b;
    } out_t;

    vec_t tbl [10];
    out_t got [$];
    int   checks = 0;
    int   errors = 0;
    int   n_issue = 0;
    int   n_taken = 0;
    logic chk_inv = 1'b0;
    logic saw_full = 1'b0;

    function automatic logic [15:0] gcd_f(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the GCD engine just after the rising edge
    task automatic tick();
        logic        cap, tkn, rst_s;
        logic [15:0] ca, cb;
        @(negedge clk);
        rst_s = reset;
        cap   = gcd_input_available && gcd_idle;
        ca    = gcd_operand_a;
        cb    = gcd_operand_b;
        tkn   = gcd_result_taken;
        if (rst_s) begin
            if (gcd_input_available) n_issue++;
            if (tkn) n_taken++;
            if (out_valid && out_ready) got.push_back({out_result, out_a, out_b});
        end
        if (fifo_count == 3'd4) saw_full = 1'b1;
        if (chk_inv) check("in_ready_vs_count", int'(in_ready), int'(fifo_count != 3'd4));
        @(posedge clk);
        #1;
        if (!rst_s) begin
            g_busy = 1'b0;
            g_rdy  = 1'b0;
        end else begin
            if (tkn) g_rdy = 1'b0;
            if (g_busy) begin
                if (g_lat <= 1) begin
                    g_busy = 1'b0;
                    g_rdy  = 1'b1;
                end else begin
                    g_lat--;
                end
            end
            if (cap) begin
                g_busy = 1'b1;
                g_lat  = lat_cfg;
                g_res  = gcd_f(ca, cb);
            end
        end
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int num, input int budget);
        int n;
        n = 0;
        while (got.size() < num && n < budget) begin
            tick();
            n++;
        end
        check("results_collected", got.size() >= num ? 1 : 0, 1);
    endtask

    task automatic check_got(input int idx, input vec_t v);
        if (idx < got.size()) begin
            check("res_value", int'(got[idx].r), int'(v.r));
            check("res_tag_a", int'(got[idx].a), int'(v.a));
            check("res_tag_b", int'(got[idx].b), int'(v.b));
        end else begin
            check("res_missing", idx, got.size());
        end
    endtask

    initial begin
        int n;
        int snap;
        tbl[0] = '{a:16'd30,  b:16'd15, r:16'd15};
        tbl[1] = '{a:16'd12,  b:16'd8,  r:16'd4};
        tbl[2] = '{a:16'd7,   b:16'd5,  r:16'd1};
        tbl[3] = '{a:16'd100, b:16'd75, r:16'd25};
        tbl[4] = '{a:16'd9,   b:16'd6,  r:16'd3};
        tbl[5] = '{a:16'd48,  b:16'd18, r:16'd6};
        tbl[6] = '{a:16'd0,   b:16'd5,  r:16'd5};
        tbl[7] = '{a:16'd14,  b:16'd21, r:16'd7};
        tbl[8] = '{a:16'd17,  b:16'd17, r:16'd17};
        tbl[9] = '{a:16'd64,  b:16'd40, r:16'd8};

        // reset state
        reset = 1'b0;
        tick();
        tick();
        check("rst_count", int'(fifo_count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_avail", int'(gcd_input_available), 0);
        check("rst_taken", int'(gcd_result_taken), 0);
        check("rst_out_result", int'(out_result), 0);
        check("rst_out_a", int'(out_a), 0);
        check("rst_out_b", int'(out_b), 0);
        reset = 1'b1;
        tick();

        // single operation and issue latency
        lat_cfg  = 2;
        in_valid = 1'b1;
        in_a     = 16'd27;
        in_b     = 16'd15;
        tick();
        in_valid = 1'b0;
        check("single_count_after_push", int'(fifo_count), 1);
        check("single_avail_early", int'(gcd_input_available), 0);
        tick();
        check("single_avail", int'(gcd_input_available), 1);
        check("single_op_a", int'(gcd_operand_a), 27);
        check("single_op_b", int'(gcd_operand_b), 15);
        tick();
        check("single_avail_one_cycle", int'(gcd_input_available), 0);
        check("single_count_after_pop", int'(fifo_count), 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("single_valid", int'(out_valid), 1);
        check("single_result", int'(out_result), 3);
        check("single_out_a", int'(out_a), 27);
        check("single_out_b", int'(out_b), 15);
        tick();
        tick();
        check("single_hold_result", int'(out_result), 3);
        check("single_taken_pulses", n_taken, 1);
        check("single_issue_pulses", n_issue, 1);
        out_ready = 1'b1;
        tick();
        check("single_popped", int'(out_valid), 0);
        got.delete();

        // burst to full, results in order
        lat_cfg  = 6;
        saw_full = 1'b0;
        chk_inv  = 1'b1;
        for (int i = 0; i < 5; i++) push_pair(tbl[i].a, tbl[i].b);
        wait_got(5, 500);
        chk_inv = 1'b0;
        check("burst_reached_full", int'(saw_full), 1);
        for (int i = 0; i < 5; i++) check_got(i, tbl[i]);
        got.delete();

        // consumer backpressure
        lat_cfg   = 2;
        out_ready = 1'b0;
        push_pair(16'd21, 16'd14);
        push_pair(16'd40, 16'd24);
        n = 0;
        while (!(out_valid && gcd_result_rdy) && n < 100) begin
            tick();
            n++;
        end
        check("bp_second_ready", int'(out_valid && gcd_result_rdy), 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_taken_low", int'(gcd_result_taken), 0);
            check("bp_hold_result", int'(out_result), 7);
            tick();
        end
        check("bp_no_reissue", int'(gcd_input_available), 0);
        out_ready = 1'b1;
        #1;
        check("bp_taken_on_release", int'(gcd_result_taken), 1);
        tick();
        check("bp_first_popped", got.size(), 1);
        check_got(0, '{a:16'd21, b:16'd14, r:16'd7});
        check("bp_reload_valid", int'(out_valid), 1);
        check("bp_reload_result", int'(out_result), 8);
        check("bp_reload_a", int'(out_a), 40);
        check("bp_reload_b", int'(out_b), 24);
        tick();
        got.delete();

        // simultaneous push/pop at count 2, pointers wrapping
        lat_cfg    = 3;
        idle_block = 1'b1;
        snap = n_issue;
        push_pair(tbl[5].a, tbl[5].b);
        push_pair(tbl[6].a, tbl[6].b);
        check("pp_count_two", int'(fifo_count), 2);
        check("pp_no_issue_blocked", n_issue, snap);
        idle_block = 1'b0;
        tick();
        check("pp_issue_state", int'(gcd_input_available), 1);
        push_pair(tbl[7].a, tbl[7].b);
        check("pp_count_unchanged", int'(fifo_count), 2);
        push_pair(tbl[8].a, tbl[8].b);
        push_pair(tbl[9].a, tbl[9].b);
        wait_got(5, 500);
        for (int i = 0; i < 5; i++) check_got(i, tbl[5 + i]);
        got.delete();

        // reset while waiting for a result with three pairs queued
        lat_cfg = 20;
        for (int i = 0; i < 4; i++) push_pair(tbl[i].a, tbl[i].b);
        check("rw_count_three", int'(fifo_count), 3);
        check("rw_result_pending", int'(gcd_result_rdy), 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rw_count_cleared", int'(fifo_count), 0);
        check("rw_valid_cleared", int'(out_valid), 0);
        check("rw_in_ready", int'(in_ready), 1);
        snap = n_issue;
        for (int i = 0; i < 5; i++) tick();
        check("rw_no_issue", n_issue, snap);
        check("rw_no_result", got.size(), 0);
        lat_cfg = 2;
        push_pair(16'd81, 16'd27);
        wait_got(1, 100);
        check_got(0, '{a:16'd81, b:16'd27, r:16'd27});
        got.delete();

        // GCD busy: no issue until idle returns
        idle_block = 1'b1;
        snap = n_issue;
        push_pair(16'd36, 16'd24);
        for (int i = 0; i < 4; i++) tick();
        check("idle_no_issue", n_issue, snap);
        check("idle_count_held", int'(fifo_count), 1);
        check("idle_avail_low", int'(gcd_input_available), 0);
        idle_block = 1'b0;
        tick();
        check("idle_issue_next", int'(gcd_input_available), 1);
        check("idle_issue_op_a", int'(gcd_operand_a), 36);
        wait_got(1, 100);
        check_got(0, '{a:16'd36, b:16'd24, r:16'd12});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
